// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
// Hazard detection and forwarding control for the 5-stage pipeline (F, D, E, M, W).
//  - Combinational forwarding selects for the E-stage ALU operands and the
//    D-stage branch comparator.
//  - A small FSM generates load-use bubbles (LOAD_LAT cycles per hazard) and
//    holds the front of the pipe while a multi-cycle mul/div is busy.
//  - A saturating counter records how many cycles the fetch stage was stalled.

module hazard_ctrl_unit #(
    parameter int REG_W    = 5,   // register-address width
    parameter int LOAD_LAT = 1,   // bubbles per load-use hazard, 1..15
    parameter int CNT_W    = 32   // stall performance counter width
) (
    input  logic             CLK,
    input  logic             RST,
    // D stage
    input  logic [REG_W-1:0] RsD,
    input  logic [REG_W-1:0] RtD,
    input  logic             UsesRsD,
    input  logic             UsesRtD,
    input  logic             BranchD,
    input  logic             JumpRegD,
    input  logic             TakenD,
    // E stage
    input  logic [REG_W-1:0] RsE,
    input  logic [REG_W-1:0] RtE,
    input  logic             RegWriteE,
    input  logic             MemtoRegE,
    input  logic [REG_W-1:0] WriteRegE,
    input  logic             MdStartE,
    input  logic             MdDone,
    // M stage
    input  logic             RegWriteM,
    input  logic             MemtoRegM,
    input  logic [REG_W-1:0] WriteRegM,
    // W stage
    input  logic             RegWriteW,
    input  logic [REG_W-1:0] WriteRegW,
    // pipeline register control
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    // forwarding selects
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    // performance counter
    output logic [CNT_W-1:0] StallCount
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [REG_W-1:0] REG_ZERO  = {REG_W{1'b0}};
    localparam logic [3:0]       LD_INIT   = 4'(LOAD_LAT - 1);
    localparam logic             LD_MULTI  = (LOAD_LAT > 1) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] FWD_RF = 2'b00;  // register file value
    localparam logic [1:0] FWD_W  = 2'b01;  // W-stage result
    localparam logic [1:0] FWD_M  = 2'b10;  // M-stage ALU result

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_MDBUSY  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Register-match helper: a write to r0 never creates a dependency.
    // ------------------------------------------------------------------
    function automatic logic reg_match(input logic [REG_W-1:0] x,
                                       input logic [REG_W-1:0] r,
                                       input logic             we);
        return we & (r != REG_ZERO) & (x == r);
    endfunction

    // True when the D-stage instruction actually reads register r.
    function automatic logic d_reads(input logic [REG_W-1:0] r,
                                     input logic [REG_W-1:0] rs,
                                     input logic [REG_W-1:0] rt,
                                     input logic             uses_rs,
                                     input logic             uses_rt);
        return (uses_rs & reg_match(rs, r, 1'b1)) |
               (uses_rt & reg_match(rt, r, 1'b1));
    endfunction

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_next_state;
    logic [3:0]       r_ldcnt;
    logic [3:0]       w_next_ldcnt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_lwstall;
    logic             w_brstall;
    logic             w_do_run;
    logic             w_stall_fd;
    logic             w_stall_e;
    logic             w_flush_e;
    logic             w_flush_m;
    logic             w_stall_f_out;
    logic             w_stall_d_out;

    // ------------------------------------------------------------------
    // Forwarding
    // ------------------------------------------------------------------

    // E-stage operand forwarding; the younger M result beats the W result.
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (reg_match(RsE, WriteRegM, RegWriteM)) begin
            ForwardAE = FWD_M;
        end else if (reg_match(RsE, WriteRegW, RegWriteW)) begin
            ForwardAE = FWD_W;
        end else begin
            ForwardAE = FWD_RF;
        end
        if (reg_match(RtE, WriteRegM, RegWriteM)) begin
            ForwardBE = FWD_M;
        end else if (reg_match(RtE, WriteRegW, RegWriteW)) begin
            ForwardBE = FWD_W;
        end else begin
            ForwardBE = FWD_RF;
        end
    end

    // D-stage comparator forwarding; a load in M has no data yet, so never forward it.
    always_comb begin
        ForwardAD = reg_match(RsD, WriteRegM, RegWriteM) & ~MemtoRegM;
        ForwardBD = reg_match(RtD, WriteRegM, RegWriteM) & ~MemtoRegM;
    end

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------

    // Load-use and branch-operand hazards against the instructions ahead of D.
    always_comb begin
        w_lwstall = MemtoRegE & RegWriteE &
                    d_reads(WriteRegE, RsD, RtD, UsesRsD, UsesRtD);
        w_brstall = (BranchD | JumpRegD) &
                    ((RegWriteE & d_reads(WriteRegE, RsD, RtD, UsesRsD, UsesRtD)) |
                     (MemtoRegM & d_reads(WriteRegM, RsD, RtD, UsesRsD, UsesRtD)));
    end

    // ------------------------------------------------------------------
    // Stall FSM
    // ------------------------------------------------------------------

    // State and load-bubble counter register; reset drops any pending stall.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_RUN;
            r_ldcnt <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_ldcnt <= w_next_ldcnt;
        end
    end

    // Next-state and raw stall/flush decode. The cycle mul/div completes is
    // evaluated exactly like RUN so a new hazard or mul/div is not lost.
    always_comb begin
        w_next_state = r_state;
        w_next_ldcnt = r_ldcnt;
        w_do_run     = 1'b0;
        w_stall_fd   = 1'b0;
        w_stall_e    = 1'b0;
        w_flush_e    = 1'b0;
        w_flush_m    = 1'b0;

        case (r_state)
            ST_RUN: begin
                w_do_run = 1'b1;
            end
            ST_LDSTALL: begin
                w_stall_fd = 1'b1;
                w_flush_e  = 1'b1;
                if (r_ldcnt <= 4'd1) begin
                    w_next_state = ST_RUN;
                    w_next_ldcnt = 4'd0;
                end else begin
                    w_next_state = ST_LDSTALL;
                    w_next_ldcnt = r_ldcnt - 4'd1;
                end
            end
            ST_MDBUSY: begin
                if (MdDone) begin
                    w_do_run = 1'b1;
                end else begin
                    w_next_state = ST_MDBUSY;
                    w_stall_fd   = 1'b1;
                    w_stall_e    = 1'b1;
                    w_flush_m    = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_RUN;
                w_next_ldcnt = 4'd0;
            end
        endcase

        if (w_do_run) begin
            if (MdStartE) begin
                // A branch waiting on E/M operands still has to hold this cycle.
                w_next_state = ST_MDBUSY;
                w_stall_fd   = w_brstall;
                w_flush_e    = w_brstall;
            end else if (w_lwstall) begin
                w_stall_fd = 1'b1;
                w_flush_e  = 1'b1;
                if (LD_MULTI) begin
                    w_next_state = ST_LDSTALL;
                    w_next_ldcnt = LD_INIT;
                end else begin
                    w_next_state = ST_RUN;
                end
            end else if (w_brstall) begin
                w_stall_fd   = 1'b1;
                w_flush_e    = 1'b1;
                w_next_state = ST_RUN;
            end else begin
                w_next_state = ST_RUN;
            end
        end else begin
            w_next_state = w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------

    // Pipeline control; every stall and flush is held low while in reset.
    always_comb begin
        w_stall_f_out = ~RST & w_stall_fd;
        w_stall_d_out = ~RST & w_stall_fd;
        StallF        = w_stall_f_out;
        StallD        = w_stall_d_out;
        StallE        = ~RST & w_stall_e;
        FlushE        = ~RST & w_flush_e;
        FlushM        = ~RST & w_flush_m;
        // A held D stage re-resolves its redirect next cycle, so don't flush it now.
        FlushD        = ~RST & TakenD & ~w_stall_d_out;
    end

    // ------------------------------------------------------------------
    // Performance counter
    // ------------------------------------------------------------------

    // Count fetch-stall cycles, sticking at all-ones instead of wrapping.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt <= {CNT_W{1'b0}};
        end else if (w_stall_f_out && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign StallCount = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed testbench for hazard_ctrl_unit (LOAD_LAT=3, 4-bit stall counter).

module tb_hazard_ctrl_unit;

    localparam int REG_W    = 5;
    localparam int LOAD_LAT = 3;
    localparam int CNT_W    = 4;

    logic             CLK;
    logic             RST;
    logic [REG_W-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic             UsesRsD, UsesRtD, BranchD, JumpRegD, TakenD;
    logic             RegWriteE, MemtoRegE, MdStartE, MdDone;
    logic             RegWriteM, MemtoRegM, RegWriteW;
    logic             StallF, StallD, StallE, FlushD, FlushE, FlushM;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             ForwardAD, ForwardBD;
    logic [CNT_W-1:0] StallCount;

    int n_total;
    int n_bad;

    hazard_ctrl_unit #(
        .REG_W   (REG_W),
        .LOAD_LAT(LOAD_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RsD       (RsD),
        .RtD       (RtD),
        .UsesRsD   (UsesRsD),
        .UsesRtD   (UsesRtD),
        .BranchD   (BranchD),
        .JumpRegD  (JumpRegD),
        .TakenD    (TakenD),
        .RsE       (RsE),
        .RtE       (RtE),
        .RegWriteE (RegWriteE),
        .MemtoRegE (MemtoRegE),
        .WriteRegE (WriteRegE),
        .MdStartE  (MdStartE),
        .MdDone    (MdDone),
        .RegWriteM (RegWriteM),
        .MemtoRegM (MemtoRegM),
        .WriteRegM (WriteRegM),
        .RegWriteW (RegWriteW),
        .WriteRegW (WriteRegW),
        .StallF    (StallF),
        .StallD    (StallD),
        .StallE    (StallE),
        .FlushD    (FlushD),
        .FlushE    (FlushE),
        .FlushM    (FlushM),
        .ForwardAE (ForwardAE),
        .ForwardBE (ForwardBE),
        .ForwardAD (ForwardAD),
        .ForwardBD (ForwardBD),
        .StallCount(StallCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // let combinational outputs settle after an input change
    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        RsD = 5'd0; RtD = 5'd0; UsesRsD = 1'b0; UsesRtD = 1'b0;
        BranchD = 1'b0; JumpRegD = 1'b0; TakenD = 1'b0;
        RsE = 5'd0; RtE = 5'd0; RegWriteE = 1'b0; MemtoRegE = 1'b0; WriteRegE = 5'd0;
        MdStartE = 1'b0; MdDone = 1'b0;
        RegWriteM = 1'b0; MemtoRegM = 1'b0; WriteRegM = 5'd0;
        RegWriteW = 1'b0; WriteRegW = 5'd0;
    endtask

    task automatic do_reset();
        clear_inputs();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    // load to reg 9 in E, D reads reg 9 through Rs
    task automatic load_use();
        MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd9;
        UsesRsD = 1'b1; RsD = 5'd9;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        clear_inputs();
        RST = 1'b1;

        // ---------------- reset behaviour ----------------
        tick();
        tick();
        load_use();
        settle();
        check_val("rst_stallF_forced0", 32'(StallF), 32'd0);
        check_val("rst_flushE_forced0", 32'(FlushE), 32'd0);
        check_val("rst_count", 32'(StallCount), 32'd0);
        // forwarding is live during reset
        clear_inputs();
        RegWriteM = 1'b1; WriteRegM = 5'd8; RsE = 5'd8;
        settle();
        check_val("rst_fwdAE", 32'(ForwardAE), 32'd2);
        tick();
        RST = 1'b0;
        clear_inputs();

        // ---------------- forwarding (test 1) ----------------
        RegWriteM = 1'b1; WriteRegM = 5'd8; RegWriteW = 1'b1; WriteRegW = 5'd8;
        RsE = 5'd8; RtE = 5'd0;
        settle();
        check_val("fwdAE_M_prio", 32'(ForwardAE), 32'd2);
        check_val("fwdBE_r0", 32'(ForwardBE), 32'd0);
        WriteRegM = 5'd0;
        settle();
        check_val("fwdAE_W", 32'(ForwardAE), 32'd1);
        RtE = 5'd8; RsE = 5'd3; WriteRegM = 5'd8; RegWriteM = 1'b0;
        settle();
        check_val("fwdBE_W_noWE_M", 32'(ForwardBE), 32'd1);
        check_val("fwdAE_none", 32'(ForwardAE), 32'd0);
        RegWriteM = 1'b1;
        settle();
        check_val("fwdBE_M", 32'(ForwardBE), 32'd2);
        clear_inputs();

        // ---------------- load-use, LOAD_LAT=3 (test 2) ----------------
        do_reset();
        load_use();
        settle();
        check_val("lw_c0_stallF", 32'(StallF), 32'd1);
        check_val("lw_c0_stallD", 32'(StallD), 32'd1);
        check_val("lw_c0_flushE", 32'(FlushE), 32'd1);
        check_val("lw_c0_stallE", 32'(StallE), 32'd0);
        tick();
        MemtoRegE = 1'b0; RegWriteE = 1'b0; WriteRegE = 5'd0;
        settle();
        check_val("lw_c1_stallF", 32'(StallF), 32'd1);
        check_val("lw_c1_flushE", 32'(FlushE), 32'd1);
        tick();
        check_val("lw_c2_stallD", 32'(StallD), 32'd1);
        tick();
        check_val("lw_c3_stallF", 32'(StallF), 32'd0);
        check_val("lw_c3_flushE", 32'(FlushE), 32'd0);
        check_val("lw_count", 32'(StallCount), 32'd3);
        // Rt dependency ignored when D does not use Rt
        clear_inputs();
        MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd9; RtD = 5'd9;
        settle();
        check_val("lw_rt_unused", 32'(StallF), 32'd0);
        // load to r0 never stalls
        UsesRsD = 1'b1; RsD = 5'd0; WriteRegE = 5'd0;
        settle();
        check_val("lw_r0", 32'(StallF), 32'd0);
        clear_inputs();

        // ---------------- branch hazards (test 3) ----------------
        do_reset();
        BranchD = 1'b1; UsesRsD = 1'b1; RsD = 5'd4;
        RegWriteM = 1'b1; MemtoRegM = 1'b1; WriteRegM = 5'd4;
        settle();
        check_val("br_ldM_stallF", 32'(StallF), 32'd1);
        check_val("br_ldM_flushE", 32'(FlushE), 32'd1);
        check_val("br_ldM_fwdAD", 32'(ForwardAD), 32'd0);
        tick();
        RegWriteM = 1'b0; MemtoRegM = 1'b0; WriteRegM = 5'd0;
        RegWriteW = 1'b1; WriteRegW = 5'd4;
        settle();
        check_val("br_next_stallF", 32'(StallF), 32'd0);
        check_val("br_next_fwdAD", 32'(ForwardAD), 32'd0);
        check_val("br_count", 32'(StallCount), 32'd1);
        RegWriteW = 1'b0; WriteRegW = 5'd0;
        RegWriteM = 1'b1; WriteRegM = 5'd4; RtD = 5'd4;
        settle();
        check_val("br_aluM_fwdAD", 32'(ForwardAD), 32'd1);
        check_val("br_aluM_fwdBD", 32'(ForwardBD), 32'd1);
        check_val("br_aluM_stallF", 32'(StallF), 32'd0);
        RegWriteM = 1'b0; WriteRegM = 5'd0;
        BranchD = 1'b0; JumpRegD = 1'b1;
        RegWriteE = 1'b1; WriteRegE = 5'd4;
        settle();
        check_val("jr_aluE_stallD", 32'(StallD), 32'd1);
        TakenD = 1'b1;
        settle();
        check_val("jr_stall_flushD", 32'(FlushD), 32'd0);
        WriteRegE = 5'd5;
        settle();
        check_val("jr_nodep_stallD", 32'(StallD), 32'd0);
        check_val("jr_nodep_flushD", 32'(FlushD), 32'd1);
        clear_inputs();

        // ---------------- mul/div busy (test 4) ----------------
        do_reset();
        MdStartE = 1'b1;
        settle();
        check_val("md_start_stallE", 32'(StallE), 32'd0);
        tick();
        MdStartE = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i == 3) TakenD = 1'b1;
            else        TakenD = 1'b0;
            settle();
            check_val("md_busy_stallF", 32'(StallF), 32'd1);
            check_val("md_busy_stallE", 32'(StallE), 32'd1);
            check_val("md_busy_flushM", 32'(FlushM), 32'd1);
            check_val("md_busy_flushD", 32'(FlushD), 32'd0);
            tick();
        end
        MdDone = 1'b1; TakenD = 1'b1;
        settle();
        check_val("md_done_stallF", 32'(StallF), 32'd0);
        check_val("md_done_stallE", 32'(StallE), 32'd0);
        check_val("md_done_flushM", 32'(FlushM), 32'd0);
        check_val("md_done_flushD", 32'(FlushD), 32'd1);
        tick();
        MdDone = 1'b0; TakenD = 1'b0;
        settle();
        check_val("md_after_stallD", 32'(StallD), 32'd0);
        check_val("md_count", 32'(StallCount), 32'd5);
        // stray done in RUN is ignored
        MdDone = 1'b1;
        tick();
        MdDone = 1'b0;
        settle();
        check_val("md_stray_done", 32'(StallE), 32'd0);
        // back-to-back: new start in the done cycle re-enters busy
        MdStartE = 1'b1;
        tick();
        MdStartE = 1'b0;
        settle();
        check_val("md_b2b_busy1", 32'(StallE), 32'd1);
        MdDone = 1'b1; MdStartE = 1'b1;
        settle();
        check_val("md_b2b_donecyc", 32'(StallE), 32'd0);
        tick();
        MdDone = 1'b0; MdStartE = 1'b0;
        settle();
        check_val("md_b2b_busy2", 32'(StallE), 32'd1);
        MdDone = 1'b1;
        tick();
        MdDone = 1'b0;

        // ---------------- reset mid-stall (test 5) ----------------
        do_reset();
        load_use();
        tick();
        clear_inputs();
        settle();
        check_val("rs_ld1_stallF", 32'(StallF), 32'd1);
        tick();
        RST = 1'b1;
        settle();
        check_val("rs_ld2_forced0", 32'(StallF), 32'd0);
        tick();
        RST = 1'b0;
        settle();
        check_val("rs_after_stallF", 32'(StallF), 32'd0);
        check_val("rs_after_flushE", 32'(FlushE), 32'd0);
        check_val("rs_after_count", 32'(StallCount), 32'd0);
        // reset while mul/div busy aborts it without MdDone
        MdStartE = 1'b1;
        tick();
        MdStartE = 1'b0;
        settle();
        check_val("rs_md_busy", 32'(StallE), 32'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        settle();
        check_val("rs_md_abort_stallE", 32'(StallE), 32'd0);
        check_val("rs_md_abort_flushM", 32'(FlushM), 32'd0);

        // ---------------- counter saturation (test 6) ----------------
        do_reset();
        MdStartE = 1'b1;
        tick();
        MdStartE = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        check_val("sat_count14", 32'(StallCount), 32'd14);
        for (int i = 0; i < 6; i++) tick();
        check_val("sat_count15", 32'(StallCount), 32'd15);
        check_val("sat_still_stall", 32'(StallF), 32'd1);
        MdDone = 1'b1;
        tick();
        MdDone = 1'b0;
        settle();
        check_val("sat_hold", 32'(StallCount), 32'd15);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
